// File: rtl/rv32_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring quotient bit per cycle,
// with start/busy/done handshake and kill for pipeline flushes.
module rv32_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state;
  logic            is_rem_q;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [CW-1:0]   cnt;

  logic            is_signed;
  logic            rs1_neg;
  logic            rs2_neg;
  logic            ovf;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // op[0] clear selects the signed variants (DIV/REM)
  assign is_signed = ~op[0];
  assign rs1_neg   = is_signed & rs1[XLEN-1];
  assign rs2_neg   = is_signed & rs2[XLEN-1];
  assign rs1_mag   = rs1_neg ? -rs1 : rs1;
  assign rs2_mag   = rs2_neg ? -rs2 : rs2;
  assign ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);

  // Remainder stays below the divisor, so the XLEN+1-bit difference sign is exact
  assign shifted = {rem_q, dvd_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign quo_fix = neg_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_r ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            is_rem_q <= op[1];
            neg_q    <= rs1_neg ^ rs2_neg;
            neg_r    <= rs1_neg;
            dvd_q    <= rs1_mag;
            dvs_q    <= rs2_mag;
            rem_q    <= '0;
            cnt      <= '0;
            if (rs2 == '0) begin
              result <= op[1] ? rs1 : '1;
              done   <= 1'b1;
              state  <= DONE;
            end else if (ovf) begin
              result <= op[1] ? '0 : rs1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            dvd_q <= {dvd_q[XLEN-2:0], ~diff[XLEN]};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) begin
              state <= SIGN;
            end
          end
        end
        SIGN: begin
          busy <= 1'b0;
          if (kill) begin
            state <= IDLE;
          end else begin
            result <= is_rem_q ? rem_fix : quo_fix;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_div_unit.sv
// Randomised and directed bench for rv32_div_unit against a cycle-level handshake model
// whose results come from plain integer division.
module tb_rv32_div_unit;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  rv32_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .rs1(rs1), .rs2(rs2), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Handshake model: what busy/done/result must be in the cycle after each edge
  int          ph = 0;
  int          left = 0;
  bit          armed = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_val = '0;

  always @(posedge clk) begin
    armed  = 1'b1;
    m_done = 1'b0;
    if (rst) begin
      ph = 0; m_busy = 1'b0; m_res = '0;
    end else if (ph == 0) begin
      if (start && !kill) begin
        m_val = ref_div(op, rs1, rs2);
        if (is_special(op, rs1, rs2)) begin
          m_res = m_val; m_done = 1'b1; ph = 2;
        end else begin
          left = XLEN + 1; m_busy = 1'b1; ph = 1;
        end
      end
    end else if (ph == 1) begin
      if (kill) begin
        ph = 0; m_busy = 1'b0;
      end else begin
        left--;
        if (left == 0) begin
          m_res = m_val; m_done = 1'b1; m_busy = 1'b0; ph = 2;
        end
      end
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("result", result, m_res);
      check("busy_and_done", {31'b0, busy & done}, 32'd0);
    end
  end

  logic [31:0] last_res = '0;

  // kind: 0 plain, 1 stray start at cycle `at`, 2 kill at `at`, 3 reset at `at`
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int kind, input int at, input logic [31:0] exp, input int exp_lat,
                     input string nm);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      start = (kind == 1 && lat == at);
      kill  = (kind == 2 && lat == at);
      rst   = (kind == 3 && lat == at);
      if (kind == 1 && lat == at) begin
        op = 2'b10; rs1 = 32'd5; rs2 = 32'd3;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; kill = 1'b0; rst = 1'b0;
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_res"}, result, exp);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b, e;
    int          kind, at;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    check("pin_div", ref_div(2'b00, 32'd100, 32'd7), 32'd14);
    check("pin_rem_neg", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    run(2'b00, 32'd100, 32'd7, 0, 0, 32'd14, 34, "div_100_7");
    run(2'b10, 32'd100, 32'd7, 0, 0, 32'd2, 34, "rem_100_7");
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFD, 34, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'h7FFF_FFFF, 34, "divu_max_2");
    run(2'b11, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd1, 34, "remu_max_2");
    run(2'b00, 32'h1234_5678, 32'd0, 0, 0, 32'hFFFF_FFFF, 1, "div_by0");
    run(2'b01, 32'h1234_5678, 32'd0, 0, 0, 32'hFFFF_FFFF, 1, "divu_by0");
    run(2'b10, 32'h1234_5678, 32'd0, 0, 0, 32'h1234_5678, 1, "rem_by0");
    run(2'b11, 32'h1234_5678, 32'd0, 0, 0, 32'h1234_5678, 1, "remu_by0");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 1, "rem_ovf");
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 34, "divu_ovf_ops");
    run(2'b00, 32'd100, 32'd7, 1, 10, 32'd14, 34, "stray_start");
    run(2'b00, 32'd200, 32'd9, 2, 20, 32'd14, 60, "kill_c20");
    run(2'b00, 32'd200, 32'd9, 3, 15, 32'd0, 60, "reset_c15");
    run(2'b00, 32'd9, 32'd3, 0, 0, 32'd3, 34, "div_9_3");
    last_res = 32'd3;

    for (int i = 0; i < 200; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 17));
        3: b = -32'($urandom_range(1, 17));
        4: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      e = ref_div(o, a, b);
      kind = 0; at = 0;
      if (!is_special(o, a, b)) begin
        case ($urandom_range(0, 9))
          0: begin kind = 2; at = $urandom_range(1, 33); end
          1: begin kind = 1; at = $urandom_range(1, 33); end
          default: ;
        endcase
      end
      if (kind == 2) begin
        run(o, a, b, kind, at, last_res, 60, "rand_kill");
      end else begin
        run(o, a, b, kind, at, e, is_special(o, a, b) ? 1 : 34, "rand");
        last_res = e;
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
